// File: rtl/dmem_mmio.sv
// Data-side slave for the RV32I core: word-addressed RAM plus a 16-byte MMIO window
// holding a byte TX FIFO and, when DMEM_MMIO_TIMER_EN is defined, a cycle timer.
module dmem_mmio #(
    parameter int unsigned DMEM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'h0001_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq
);

    localparam int unsigned AW = $clog2(DMEM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLE  = 2'd2;
    localparam logic [1:0] OFF_CMP    = 2'd3;

    logic [31:0]   r_mem [DMEM_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_tx_valid;

    logic          w_ram_sel;
    logic          w_mmio_sel;
    logic [AW-1:0] w_ram_idx;
    logic [1:0]    w_off;
    logic          w_tx_wr;
    logic          w_stat_clr;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_count_nxt;
    logic [31:0]   w_status;
    logic [31:0]   w_cycle_rd;
    logic [31:0]   w_cmp_rd;
    logic          w_unused;

    // Address decode; the core performs its own byte-lane extraction.
    assign w_ram_sel  = (daddr[31:AW+2] == '0);
    assign w_mmio_sel = (daddr[31:4] == MMIO_BASE[31:4]);
    assign w_ram_idx  = daddr[AW+1:2];
    assign w_off      = daddr[3:2];
    assign w_unused   = ^{daddr[1:0]};

    assign w_tx_wr    = w_mmio_sel && (w_off == OFF_TXDATA) && dwe[0];
    assign w_stat_clr = w_mmio_sel && (w_off == OFF_STATUS) && dwe[0] && dwdata[2];

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_pop    = r_tx_valid && tx_ready;
    assign w_push   = w_tx_wr && (!w_full || w_pop);
    assign w_status = {16'b0, 8'(r_count), 5'b0, r_ovf, w_full, w_empty};

    assign tx_valid = r_tx_valid;
    assign tx_data  = r_fifo[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Combinational read so loads write back in the same cycle.
    always_comb begin
        drdata = '0;
        if (w_ram_sel) begin
            drdata = r_mem[w_ram_idx];
        end else if (w_mmio_sel) begin
            case (w_off)
                OFF_STATUS: drdata = w_status;
                OFF_CYCLE:  drdata = w_cycle_rd;
                OFF_CMP:    drdata = w_cmp_rd;
                default:    drdata = '0;
            endcase
        end
    end

    // Byte-lane RAM write; contents survive reset but writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (reset && w_ram_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (dwe[i]) begin
                    r_mem[w_ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_fifo[r_wr_ptr] <= dwdata[7:0];
        end
    end

    // FIFO control; push while full is accepted only when the head leaves in the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_tx_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count    <= w_count_nxt;
            r_tx_valid <= (w_count_nxt != '0);
            if (w_tx_wr && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_stat_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef DMEM_MMIO_TIMER_EN
    logic [31:0] r_cycle;
    logic [31:0] r_cmp;
    logic        r_irq;
    logic        w_cyc_wr;
    logic        w_cmp_wr;

    assign w_cyc_wr = w_mmio_sel && (w_off == OFF_CYCLE) && (dwe == 4'b1111);
    assign w_cmp_wr = w_mmio_sel && (w_off == OFF_CMP) && (dwe == 4'b1111);

    // Match uses pre-increment count; a CMP write overrides a coincident match.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cycle <= '0;
            r_cmp   <= 32'hFFFF_FFFF;
            r_irq   <= 1'b0;
        end else begin
            r_cycle <= w_cyc_wr ? dwdata : r_cycle + 32'd1;
            if (w_cmp_wr) begin
                r_cmp <= dwdata;
                r_irq <= 1'b0;
            end else if (r_cycle == r_cmp) begin
                r_irq <= 1'b1;
            end
        end
    end

    assign w_cycle_rd = r_cycle;
    assign w_cmp_rd   = r_cmp;
    assign timer_irq  = r_irq;
`else
    assign w_cycle_rd = '0;
    assign w_cmp_rd   = '0;
    assign timer_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue/array reference model.
module tb_dmem_mmio;

    localparam int unsigned DW    = 1024;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] MMIO  = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Reference model state
    logic [31:0] m_mem   [DW];
    logic [3:0]  m_known [DW];
    logic [7:0]  q [$];
    bit          m_ovf;
    logic [31:0] m_cycle;
    logic [31:0] m_cmp;
    bit          m_irq;

    int          sz;
    bit          pop;
    logic [31:0] ev, em;

    dmem_mmio #(.DMEM_WORDS(DW), .MMIO_BASE(MMIO), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
        .drdata(drdata), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        return {16'b0, 8'(q.size()), 5'b0, m_ovf, q.size() == DEPTH, q.size() == 0};
    endfunction

    // Expected read word plus a mask of bytes the model actually knows.
    function automatic void model_read(input logic [31:0] a, output logic [31:0] v, output logic [31:0] m);
        int idx;
        v = '0;
        m = '1;
        if (a < 32'(DW * 4)) begin
            idx = int'(a[11:2]);
            v = m_mem[idx];
            m = {{8{m_known[idx][3]}}, {8{m_known[idx][2]}}, {8{m_known[idx][1]}}, {8{m_known[idx][0]}}};
        end else if (a[31:4] == MMIO[31:4]) begin
            case (a[3:2])
                2'd1: v = model_status();
`ifdef DMEM_MMIO_TIMER_EN
                2'd2: v = m_cycle;
                2'd3: v = m_cmp;
`endif
                default: v = '0;
            endcase
        end
    endfunction

    // Model advance at each rising edge, using the inputs held across that edge.
    always @(posedge clk) begin
        if (!reset) begin
            q.delete();
            m_ovf   = 0;
            m_cycle = '0;
            m_cmp   = 32'hFFFF_FFFF;
            m_irq   = 0;
        end else begin
            if (daddr < 32'(DW * 4)) begin
                for (int i = 0; i < 4; i++) begin
                    if (dwe[i]) begin
                        m_mem[daddr[11:2]][8*i +: 8] = dwdata[8*i +: 8];
                        m_known[daddr[11:2]][i] = 1'b1;
                    end
                end
            end
            sz  = q.size();
            pop = (sz != 0) && tx_ready;
            if (pop) void'(q.pop_front());
            if (daddr[31:4] == MMIO[31:4]) begin
                if (daddr[3:2] == 2'd0 && dwe[0]) begin
                    if (sz < DEPTH || pop) q.push_back(dwdata[7:0]);
                    else m_ovf = 1;
                end
                if (daddr[3:2] == 2'd1 && dwe[0] && dwdata[2]) m_ovf = 0;
            end
`ifdef DMEM_MMIO_TIMER_EN
            if (daddr[31:4] == MMIO[31:4] && daddr[3:2] == 2'd3 && dwe == 4'hF) begin
                m_cmp = dwdata;
                m_irq = 0;
            end else if (m_cycle == m_cmp) begin
                m_irq = 1;
            end
            if (daddr[31:4] == MMIO[31:4] && daddr[3:2] == 2'd2 && dwe == 4'hF) m_cycle = dwdata;
            else m_cycle = m_cycle + 32'd1;
`endif
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            model_read(daddr, ev, em);
            check("drdata", drdata & em, ev & em);
            check("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
            if (q.size() != 0) check("tx_data", 32'(tx_data), 32'(q[0]));
            check("timer_irq", 32'(timer_irq), 32'(m_irq));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we, input logic rdy);
        daddr = a; dwdata = d; dwe = we; tx_ready = rdy;
        step();
        dwe = 4'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        daddr = a; dwdata = '0; dwe = 4'b0; tx_ready = 1'b0;
        #2;
        check(name, drdata, exp);
        step();
    endtask

    task automatic drain_chk(input logic [7:0] exp, input string name);
        daddr = '0; dwe = 4'b0; tx_ready = 1'b1;
        #2;
        check(name, 32'(tx_data), 32'(exp));
        step();
    endtask

    logic [7:0]  exp4 [8];
    logic [31:0] a, d;
    logic [3:0]  we;
    int          sel;

    initial begin
        for (int i = 0; i < int'(DW); i++) m_known[i] = 4'b0;
        reset = 1'b0; daddr = '0; dwdata = '0; dwe = 4'b0; tx_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        chk_en = 1;

        // Reset state
        #2;
        check("reset_tx_valid", 32'(tx_valid), 32'd0);
        check("reset_irq", 32'(timer_irq), 32'd0);
        step();
        rd_chk(MMIO + 32'h4, 32'h0000_0001, "reset_status");

        // Byte-lane RAM write, decode boundary
        op(32'h0, 32'h1122_3344, 4'b1111, 1'b0);
        op(32'h0, 32'h0000_AA00, 4'b0010, 1'b0);
        rd_chk(32'h0, 32'h1122_AA44, "ram_lane_merge");
        op(32'(DW * 4), 32'hDEAD_BEEF, 4'b1111, 1'b0);
        rd_chk(32'h0, 32'h1122_AA44, "ram_no_alias");
        rd_chk(32'(DW * 4), 32'h0, "above_ram_zero");

        // Three pushes then ordered drain
        op(MMIO, 32'h41, 4'b0001, 1'b0);
        op(MMIO, 32'h42, 4'b0001, 1'b0);
        op(MMIO, 32'h43, 4'b0001, 1'b0);
        #2;
        check("head_41", 32'(tx_data), 32'h41);
        rd_chk(MMIO + 32'h4, 32'h0000_0300, "status_3");
        drain_chk(8'h41, "drain_41");
        drain_chk(8'h42, "drain_42");
        drain_chk(8'h43, "drain_43");
        rd_chk(MMIO + 32'h4, 32'h0000_0001, "status_drained");

        // Overflow and sticky ovf clear
        for (int i = 0; i < 9; i++) op(MMIO, 32'(8'h60 + 8'(i)), 4'b0001, 1'b0);
        rd_chk(MMIO + 32'h4, 32'h0000_0806, "status_ovf");
        op(MMIO + 32'h4, 32'h4, 4'b0001, 1'b0);
        rd_chk(MMIO + 32'h4, 32'h0000_0802, "status_ovf_clr");

        // Push into a full FIFO while popping
        op(MMIO, 32'h5A, 4'b0001, 1'b1);
        rd_chk(MMIO + 32'h4, 32'h0000_0802, "full_push_pop");
        exp4 = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h5A};
        for (int i = 0; i < 8; i++) drain_chk(exp4[i], "full_drain");
        rd_chk(MMIO + 32'h4, 32'h0000_0001, "status_empty");

        // Reset with bytes queued
        for (int i = 0; i < 4; i++) op(MMIO, 32'(8'h30 + 8'(i)), 4'b0001, 1'b0);
        reset = 1'b0;
        op(MMIO + 32'h8, 32'h0, 4'b0, 1'b0);
        reset = 1'b1;
        daddr = MMIO + 32'h8;
        #2;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_irq", 32'(timer_irq), 32'd0);
        check("rst_cycle", drdata, 32'h0);
        step();
        rd_chk(MMIO + 32'h4, 32'h0000_0001, "rst_status");
        rd_chk(32'h2000_0000, 32'h0, "unmapped_zero");

`ifdef DMEM_MMIO_TIMER_EN
        op(MMIO + 32'hC, 32'd20, 4'b1111, 1'b0);
        op(MMIO + 32'h8, 32'd10, 4'b1111, 1'b0);
        check("irq_before", 32'(timer_irq), 32'd0);
        for (int k = 0; k < 12; k++) step();
        check("irq_after", 32'(timer_irq), 32'd1);
        op(MMIO + 32'hC, 32'd100, 4'b1111, 1'b0);
        check("irq_cleared", 32'(timer_irq), 32'd0);
        rd_chk(MMIO + 32'hC, 32'd100, "cmp_read");
`else
        op(MMIO + 32'h8, 32'd10, 4'b1111, 1'b0);
        rd_chk(MMIO + 32'h8, 32'h0, "cycle_reads_zero");
        rd_chk(MMIO + 32'hC, 32'h0, "cmp_reads_zero");
`endif

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4) a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            else if (sel < 8) a = MMIO + 32'($urandom_range(0, 15));
            else if (sel == 8) a = $urandom;
            else a = 32'(DW * 4) + 32'($urandom_range(0, 15));
            we = ($urandom_range(0, 2) == 0) ? 4'b0 : (($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15)));
            d = $urandom;
            if (a[31:4] == MMIO[31:4] && a[3:2] == 2'd3 && $urandom_range(0, 1) == 1)
                d = m_cycle + 32'($urandom_range(1, 5));
            reset = ($urandom_range(0, 199) != 0);
            if (n < 1500) tx_ready = ($urandom_range(0, 3) == 0);
            else tx_ready = ($urandom_range(0, 3) != 0);
            daddr = a; dwdata = d; dwe = we;
            step();
        end
        reset = 1'b1; dwe = 4'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
